// File: rtl/shift_arbiter.sv
// shift_arbiter: round-robin arbiter feeding one shared 32-bit shifter through a
// two-stage pipeline (S1 operand register, S2 response register) with a single
// back-pressurable response port. Responses leave in acceptance order.
module shift_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*32-1:0] req_a,
    input  logic [NUM_REQ*32-1:0] req_b,
    input  logic [NUM_REQ*2-1:0]  req_op,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ID_W-1:0]       rsp_id,
    output logic [31:0]           rsp_data,
    output logic                  busy
);

    localparam logic [1:0]      OpLsh   = 2'b00;
    localparam logic [1:0]      OpRsh   = 2'b01;
    localparam logic [1:0]      OpArsh  = 2'b10;
    localparam logic [ID_W:0]   NumReqW = (ID_W + 1)'(NUM_REQ);
    localparam logic [ID_W-1:0] LastId  = ID_W'(NUM_REQ - 1);

    // Stage 1 operand register
    logic            s1_valid;
    logic [31:0]     s1_a;
    logic [4:0]      s1_amt;
    logic [1:0]      s1_op;
    logic [ID_W-1:0] s1_id;

    // Round-robin pointer: requester searched first
    logic [ID_W-1:0] ptr;

    logic               s1_adv;
    logic               s2_adv;
    logic               xfer;
    logic [NUM_REQ-1:0] req_rot;
    logic               found;
    logic [ID_W-1:0]    off;
    logic [ID_W:0]      sum;
    logic [ID_W-1:0]    gnt_id;
    logic [NUM_REQ-1:0] grant;
    logic [31:0]        g_a;
    logic [31:0]        g_b;
    logic [1:0]         g_op;
    logic [31:0]        shift_res;

    // Only b[4:0] matters; upper amount bits are deliberately ignored
    logic unused_b_hi;
    assign unused_b_hi = ^g_b[31:5];

    assign s2_adv    = !rsp_valid || rsp_ready;
    assign s1_adv    = !s1_valid || s2_adv;
    assign req_ready = (rst_n && s1_adv) ? grant : '0;
    assign xfer      = rst_n && found && s1_adv;
    assign busy      = s1_valid || rsp_valid;

    // Rotate valids so index 0 is ptr, take the first set bit, rotate back
    always_comb begin
        req_rot = NUM_REQ'({req_valid, req_valid} >> ptr);
        found   = 1'b0;
        off     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && req_rot[k]) begin
                found = 1'b1;
                off   = ID_W'(k);
            end
        end
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= NumReqW) begin
            sum = sum - NumReqW;
        end
        gnt_id = sum[ID_W-1:0];
        for (int i = 0; i < NUM_REQ; i++) begin
            grant[i] = found && (gnt_id == ID_W'(i));
        end
    end

    // Select the granted requester's operands
    always_comb begin
        g_a  = '0;
        g_b  = '0;
        g_op = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                g_a  = req_a[i*32 +: 32];
                g_b  = req_b[i*32 +: 32];
                g_op = req_op[i*2 +: 2];
            end
        end
    end

    // Shared shifter, fed from S1
    always_comb begin
        case (s1_op)
            OpLsh:   shift_res = s1_a << s1_amt;
            OpRsh:   shift_res = s1_a >> s1_amt;
            OpArsh:  shift_res = $signed(s1_a) >>> s1_amt;
            default: shift_res = s1_a;
        endcase
    end

    // Pipeline stages and round-robin pointer
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_a      <= '0;
            s1_amt    <= '0;
            s1_op     <= '0;
            s1_id     <= '0;
            ptr       <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
        end else begin
            if (xfer) begin
                s1_valid <= 1'b1;
                s1_a     <= g_a;
                s1_amt   <= g_b[4:0];
                s1_op    <= g_op;
                s1_id    <= gnt_id;
                ptr      <= (gnt_id == LastId) ? '0 : gnt_id + ID_W'(1);
            end else if (s2_adv) begin
                s1_valid <= 1'b0;
            end
            if (s2_adv) begin
                rsp_valid <= s1_valid;
                rsp_id    <= s1_id;
                rsp_data  <= shift_res;
            end
        end
    end

endmodule

// File: tb/tb_shift_arbiter.sv
// tb_shift_arbiter: scenario tasks plus a randomized run, checked against a
// request/response queue model of the arbiter and arithmetic shift rules.
module tb_shift_arbiter;

    localparam int N   = 4;
    localparam int IDW = $clog2(N);

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*32-1:0] req_a;
    logic [N*32-1:0] req_b;
    logic [N*2-1:0] req_op;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [IDW-1:0] rsp_id;
    logic [31:0]    rsp_data;
    logic           busy;

    shift_arbiter #(.NUM_REQ(N), .ID_W(IDW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { int id; logic [31:0] a; logic [31:0] b; logic [1:0] op; } req_t;
    typedef struct { int id; logic [31:0] data; int e; } item_t;

    req_t  pend[$];   // requests waiting at their source, per-requester order kept
    item_t q[$];      // accepted, not yet delivered, in acceptance order
    int    ptr_m;
    int    edge_n;
    int    tests_run;
    int    tests_failed;

    function automatic req_t make_req(int id, logic [31:0] a, logic [31:0] b, logic [1:0] op);
        req_t r;
        r.id = id; r.a = a; r.b = b; r.op = op;
        return r;
    endfunction

    // Shifts as multiply/divide by a power of two
    function automatic logic [31:0] ref_result(logic [31:0] a, logic [31:0] b, logic [1:0] op);
        longint unsigned p;
        logic [63:0]     wide;
        logic [31:0]     base;
        logic [31:0]     fill;
        int              amt;
        amt = int'(b % 32);
        p = 1;
        for (int k = 0; k < amt; k++) p = p * 2;
        wide = {32'd0, a} * p;
        base = 32'({32'd0, a} / p);
        fill = ~32'(64'hFFFF_FFFF / p);
        case (op)
            2'b00:   return wide[31:0];
            2'b01:   return base;
            2'b10:   return a[31] ? (base | fill) : base;
            default: return a;
        endcase
    endfunction

    function automatic logic [N-1:0] exp_ready();
        logic [N-1:0] r;
        r = '0;
        if (!rst_n) return r;
        if (q.size() == 2 && !rsp_ready) return r;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (ptr_m + k) % N;
            if (req_valid[idx]) begin
                r[idx] = 1'b1;
                return r;
            end
        end
        return r;
    endfunction

    function automatic logic exp_rv();
        return (q.size() > 0) && (edge_n > q[0].e);
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid[i]      = 1'b0;
            req_a[i*32 +: 32] = $urandom;
            req_b[i*32 +: 32] = $urandom;
            req_op[i*2 +: 2]  = 2'($urandom);
            for (int k = 0; k < pend.size(); k++) begin
                if (pend[k].id == i) begin
                    req_valid[i]      = 1'b1;
                    req_a[i*32 +: 32] = pend[k].a;
                    req_b[i*32 +: 32] = pend[k].b;
                    req_op[i*2 +: 2]  = pend[k].op;
                    break;
                end
            end
        end
    endtask

    // Advance one clock; update sources and model from what transferred
    task automatic tick();
        logic [N-1:0] acc;
        logic         rx;
        logic         rst_s;
        item_t        it;
        @(negedge clk);
        acc   = req_valid & req_ready;
        rx    = rsp_valid & rsp_ready;
        rst_s = rst_n;
        @(posedge clk);
        #1;
        edge_n++;
        if (rst_s !== 1'b1) begin
            q.delete();
            ptr_m = 0;
        end else begin
            if (rx === 1'b1 && q.size() > 0) q.delete(0);
            for (int i = 0; i < N; i++) begin
                if (acc[i] === 1'b1) begin
                    for (int k = 0; k < pend.size(); k++) begin
                        if (pend[k].id == i) begin
                            it.id   = i;
                            it.data = ref_result(pend[k].a, pend[k].b, pend[k].op);
                            it.e    = edge_n;
                            q.push_back(it);
                            pend.delete(k);
                            break;
                        end
                    end
                    ptr_m = (i + 1) % N;
                end
            end
        end
        drive();
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        rsp_ready = 1'b0;
        pend.delete();
        drive();
        tick();
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        rsp_ready = 1'b1;
        pend.delete();
        pend.push_back(make_req(1, 32'h1234_5678, 32'd3, 2'b00));
        drive();
        tick();
        tick();
        #1;
        tests_run += 5;
        if (req_ready !== '0) begin
            tests_failed++; $display("FAIL reset_req_ready: got %b want 0", req_ready);
        end
        if (rsp_valid !== 1'b0) begin
            tests_failed++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid);
        end
        if (rsp_id !== '0) begin
            tests_failed++; $display("FAIL reset_rsp_id: got %0d want 0", rsp_id);
        end
        if (rsp_data !== 32'h0) begin
            tests_failed++; $display("FAIL reset_rsp_data: got %h want 0", rsp_data);
        end
        if (busy !== 1'b0) begin
            tests_failed++; $display("FAIL reset_busy: got %b want 0", busy);
        end
    endtask

    task automatic test_basic_ops();
        logic [31:0] want[4] = '{32'h0000_0010, 32'h0800_0000, 32'hF800_0000, 32'h8000_0001};
        int n = 0;
        do_reset();
        for (int k = 0; k < 4; k++) pend.push_back(make_req(0, 32'h8000_0001, 32'd4, 2'(k)));
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        drive();
        for (int c = 0; c < 20 && n < 4; c++) begin
            tick();
            #1;
            if (rsp_valid === 1'b1) begin
                tests_run++;
                if (rsp_id !== '0 || rsp_data !== want[n]) begin
                    tests_failed++;
                    $display("FAIL basic_op%0d: got id %0d data %h want id 0 data %h",
                             n, rsp_id, rsp_data, want[n]);
                end
                n++;
            end
        end
        tests_run++;
        if (n != 4) begin
            tests_failed++; $display("FAIL basic_count: got %0d want 4", n);
        end
    endtask

    task automatic test_masking();
        logic [31:0] want[3] = '{32'h0000_0002, 32'hFFFF_FFFF, 32'hF000_0000};
        int n = 0;
        do_reset();
        pend.push_back(make_req(0, 32'h0000_0001, 32'd33, 2'b00));
        pend.push_back(make_req(0, 32'hFFFF_FFFF, 32'd32, 2'b01));
        pend.push_back(make_req(0, 32'h8000_0000, 32'hFFFF_FFE3, 2'b10));
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        drive();
        for (int c = 0; c < 20 && n < 3; c++) begin
            tick();
            #1;
            if (rsp_valid === 1'b1) begin
                tests_run++;
                if (rsp_id !== '0 || rsp_data !== want[n]) begin
                    tests_failed++;
                    $display("FAIL mask_op%0d: got id %0d data %h want id 0 data %h",
                             n, rsp_id, rsp_data, want[n]);
                end
                n++;
            end
        end
        tests_run++;
        if (n != 3) begin
            tests_failed++; $display("FAIL mask_count: got %0d want 3", n);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int r = 0; r < 3; r++)
            for (int i = 0; i < N; i++) pend.push_back(make_req(i, $urandom, $urandom, 2'($urandom)));
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        drive();
        tick();
        #1;
        tests_run++;
        if (rsp_valid !== 1'b0) begin
            tests_failed++; $display("FAIL rr_latency_e1: got %b want 0", rsp_valid);
        end
        tick();
        #1;
        tests_run++;
        if (rsp_valid !== 1'b1) begin
            tests_failed++; $display("FAIL rr_latency_e2: got %b want 1", rsp_valid);
        end
        for (int k = 0; k < 12; k++) begin
            tests_run++;
            if (rsp_valid !== 1'b1 || int'(rsp_id) != k % N || q.size() == 0 ||
                rsp_data !== q[0].data) begin
                tests_failed++;
                $display("FAIL rr_seq%0d: got valid %b id %0d data %h want valid 1 id %0d data %h",
                         k, rsp_valid, rsp_id, rsp_data, k % N,
                         (q.size() > 0) ? q[0].data : 32'h0);
            end
            tick();
            #1;
        end
    endtask

    task automatic test_back_pressure();
        int c;
        do_reset();
        for (int k = 0; k < 8; k++) pend.push_back(make_req(k % N, $urandom, $urandom, 2'($urandom)));
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        drive();
        tick();
        rsp_ready = 1'b0;
        for (c = 0; c < 4 && q.size() < 2; c++) tick();
        #1;
        tests_run++;
        if (q.size() != 2) begin
            tests_failed++; $display("FAIL bp_fill: got %0d in flight want 2", q.size());
        end
        for (int k = 0; k < 5; k++) begin
            tests_run += 3;
            if (req_ready !== '0) begin
                tests_failed++; $display("FAIL bp_ready%0d: got %b want 0", k, req_ready);
            end
            if (rsp_valid !== 1'b1 || busy !== 1'b1) begin
                tests_failed++;
                $display("FAIL bp_valid%0d: got valid %b busy %b want 1 1", k, rsp_valid, busy);
            end
            if (q.size() == 0 || int'(rsp_id) != q[0].id || rsp_data !== q[0].data) begin
                tests_failed++;
                $display("FAIL bp_hold%0d: got id %0d data %h want id %0d data %h", k, rsp_id,
                         rsp_data, (q.size() > 0) ? q[0].id : -1,
                         (q.size() > 0) ? q[0].data : 32'h0);
            end
            tick();
            #1;
        end
        rsp_ready = 1'b1;
        #1;
        tests_run++;
        if (req_ready === '0 || req_ready !== exp_ready()) begin
            tests_failed++;
            $display("FAIL bp_release_ready: got %b want %b", req_ready, exp_ready());
        end
        for (c = 0; c < 40 && (pend.size() > 0 || q.size() > 0); c++) begin
            tick();
            #1;
            tests_run += 2;
            if (req_ready !== exp_ready()) begin
                tests_failed++;
                $display("FAIL bp_drain_ready: got %b want %b", req_ready, exp_ready());
            end
            if (rsp_valid !== exp_rv() ||
                (exp_rv() && (int'(rsp_id) != q[0].id || rsp_data !== q[0].data))) begin
                tests_failed++;
                $display("FAIL bp_drain_rsp: got valid %b id %0d data %h want valid %b",
                         rsp_valid, rsp_id, rsp_data, exp_rv());
            end
        end
        tests_run++;
        if (pend.size() != 0 || q.size() != 0) begin
            tests_failed++;
            $display("FAIL bp_drained: got %0d pending %0d in flight want 0 0", pend.size(), q.size());
        end
    endtask

    task automatic test_fairness();
        int seq[6] = '{1, 3, 1, 3, 1, 2};
        logic [N-1:0] w;
        do_reset();
        for (int k = 0; k < 4; k++) pend.push_back(make_req(1, $urandom, $urandom, 2'($urandom)));
        for (int k = 0; k < 3; k++) pend.push_back(make_req(3, $urandom, $urandom, 2'($urandom)));
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        drive();
        #1;
        for (int k = 0; k < 6; k++) begin
            w = '0;
            w[seq[k]] = 1'b1;
            tests_run++;
            if (req_ready !== w) begin
                tests_failed++; $display("FAIL fair_grant%0d: got %b want %b", k, req_ready, w);
            end
            tick();
            if (k == 4) begin
                pend.push_back(make_req(2, $urandom, $urandom, 2'($urandom)));
                drive();
            end
            #1;
        end
    endtask

    task automatic test_mid_reset();
        int c;
        do_reset();
        for (int k = 0; k < 3; k++) pend.push_back(make_req(2, $urandom, $urandom, 2'($urandom)));
        rst_n     = 1'b1;
        rsp_ready = 1'b0;
        drive();
        for (c = 0; c < 5 && q.size() < 2; c++) tick();
        #1;
        tests_run++;
        if (rsp_valid !== 1'b1 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_full: got valid %b busy %b want 1 1", rsp_valid, busy);
        end
        rst_n = 1'b0;
        tick();
        #1;
        tests_run += 3;
        if (rsp_valid !== 1'b0) begin
            tests_failed++; $display("FAIL mid_rsp_valid: got %b want 0", rsp_valid);
        end
        if (busy !== 1'b0) begin
            tests_failed++; $display("FAIL mid_busy: got %b want 0", busy);
        end
        if (req_ready !== '0) begin
            tests_failed++; $display("FAIL mid_ready_in_reset: got %b want 0", req_ready);
        end
        rst_n = 1'b1;
        pend.push_back(make_req(0, $urandom, $urandom, 2'($urandom)));
        pend.push_back(make_req(1, $urandom, $urandom, 2'($urandom)));
        pend.push_back(make_req(3, $urandom, $urandom, 2'($urandom)));
        drive();
        #1;
        tests_run++;
        if (req_ready !== 4'b0001) begin
            tests_failed++; $display("FAIL mid_ptr_zero: got %b want 0001", req_ready);
        end
        rsp_ready = 1'b1;
        for (c = 0; c < 30 && (pend.size() > 0 || q.size() > 0); c++) begin
            tick();
            #1;
            tests_run++;
            if (rsp_valid !== exp_rv() ||
                (exp_rv() && (int'(rsp_id) != q[0].id || rsp_data !== q[0].data))) begin
                tests_failed++;
                $display("FAIL mid_after_rsp: got valid %b id %0d data %h want valid %b",
                         rsp_valid, rsp_id, rsp_data, exp_rv());
            end
        end
        tests_run++;
        if (pend.size() != 0 || q.size() != 0) begin
            tests_failed++;
            $display("FAIL mid_drained: got %0d pending %0d in flight want 0 0", pend.size(), q.size());
        end
    endtask

    task automatic test_random();
        int c;
        do_reset();
        rst_n = 1'b1;
        for (int k = 0; k < 400; k++) begin
            rsp_ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 2) != 0 && pend.size() < 12)
                pend.push_back(make_req(int'($urandom_range(0, N - 1)), $urandom, $urandom,
                                        2'($urandom)));
            drive();
            #1;
            tests_run += 3;
            if (req_ready !== exp_ready()) begin
                tests_failed++;
                $display("FAIL rand_ready@%0d: got %b want %b", k, req_ready, exp_ready());
            end
            if (rsp_valid !== exp_rv() ||
                (exp_rv() && (int'(rsp_id) != q[0].id || rsp_data !== q[0].data))) begin
                tests_failed++;
                $display("FAIL rand_rsp@%0d: got valid %b id %0d data %h want valid %b id %0d data %h",
                         k, rsp_valid, rsp_id, rsp_data, exp_rv(),
                         (q.size() > 0) ? q[0].id : -1, (q.size() > 0) ? q[0].data : 32'h0);
            end
            if (busy !== (q.size() != 0)) begin
                tests_failed++;
                $display("FAIL rand_busy@%0d: got %b want %b", k, busy, q.size() != 0);
            end
            tick();
        end
        rsp_ready = 1'b1;
        for (c = 0; c < 60 && (pend.size() > 0 || q.size() > 0); c++) tick();
        tests_run++;
        if (pend.size() != 0 || q.size() != 0) begin
            tests_failed++;
            $display("FAIL rand_drained: got %0d pending %0d in flight want 0 0", pend.size(), q.size());
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        ptr_m        = 0;
        edge_n       = 0;
        rst_n        = 1'b0;
        rsp_ready    = 1'b0;
        req_valid    = '0;
        req_a        = '0;
        req_b        = '0;
        req_op       = '0;
        test_reset();
        test_basic_ops();
        test_masking();
        test_round_robin();
        test_back_pressure();
        test_fairness();
        test_mid_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
